key_entry_buffer: RTL and testbench
===================================

KEY_ENTRY_BUFFER -- requirements
Module: key_entry_buffer

Interface
REQ-001 SHALL have parameter DIGITS, default 4: number of key digits held (range 2..16).
REQ-002 SHALL have parameter KEY_W, default 4: width of one key digit.
REQ-003 SHALL have parameter MAX_KEY, default 9: largest accepted key value.
REQ-004 SHALL have port clock  in  1  clock, all state updates on rising edge.
REQ-005 SHALL have port reset  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port shift  in  1  one-cycle strobe to enter key.
REQ-007 SHALL have port key  in  KEY_W  key value sampled with shift.
REQ-008 SHALL have port backspace  in  1  one-cycle strobe to delete the newest digit.
REQ-009 SHALL have port clear  in  1  one-cycle strobe to empty the buffer.
REQ-010 SHALL have port commit  in  1  one-cycle strobe to hand off a complete entry.
REQ-011 SHALL have port key_buffer  out  DIGITS*KEY_W  live digits; digit 0 (LSBs) is newest.
REQ-012 SHALL have port count  out  clog2(DIGITS+1)  digits currently entered.
REQ-013 SHALL have port full  out  1  count==DIGITS, and empty  out  1  count==0.
REQ-014 SHALL have port load_data  out  DIGITS*KEY_W  committed snapshot, and load_valid  out  1  one-cycle pulse.
REQ-015 SHALL have port reject  out  1  one-cycle pulse on any refused operation.

Function
REQ-016 Priority per cycle SHALL be clear > commit > shift > backspace; lower-priority strobes in the same cycle are dropped without reject.
REQ-017 shift with key<=MAX_KEY SHALL, next edge, move digit i to i+1 for all i, load key into digit 0, and increment count saturating at DIGITS.
REQ-018 shift when full SHALL discard digit DIGITS-1 (oldest), perform the shift, keep count=DIGITS; no reject.
REQ-019 shift with key>MAX_KEY SHALL leave buffer and count unchanged and pulse reject next cycle.
REQ-020 backspace when not empty SHALL move digit i+1 to i, load 0 into digit DIGITS-1, and decrement count.
REQ-021 backspace when empty SHALL change nothing and pulse reject.
REQ-022 clear SHALL zero all digits and count next edge; never rejects.
REQ-023 commit when full SHALL copy key_buffer to load_data, pulse load_valid for exactly one cycle, and zero buffer and count, all on the same edge.
REQ-024 commit when not full SHALL change nothing and pulse reject; load_valid stays 0.
REQ-025 load_data SHALL hold its value until the next successful commit.
REQ-026 All outputs SHALL be registered; response latency to any strobe is one clock edge.
REQ-027 full and empty SHALL be consistent with count in every cycle.

Reset
REQ-028 Reset SHALL clear key_buffer, load_data, count to 0, load_valid and reject to 0; empty=1, full=0.
REQ-029 Reset asserted mid-entry SHALL discard partial digits with no load_valid pulse.
REQ-030 First strobe SHALL be honoured on the first rising edge after reset deasserts.

Verification (DIGITS=4, KEY_W=4, MAX_KEY=9)
REQ-031 Reset, shift keys 1,2,3,4 -> key_buffer=16'h1234, count=4, full=1.
REQ-032 From 16'h1234 shift 5 -> key_buffer=16'h2345, count=4, reject=0.
REQ-033 From 16'h0012 (count=2) backspace, backspace, backspace -> 16'h0001, 16'h0000, then reject pulse, count=0, empty=1.
REQ-034 Shift key 4'hA -> reject pulse, buffer unchanged; commit at count=3 -> reject, load_valid=0.
REQ-035 From 16'h1234 full, commit -> load_valid one cycle, load_data=16'h1234, key_buffer=0, count=0; same-cycle clear+commit -> cleared, no load_valid.
REQ-036 Reset asserted after two shifts, asynchronously mid-cycle -> all outputs 0 immediately, empty=1.

Source files
------------

// File: rtl/key_entry_buffer.sv
`default_nettype none
// key_entry_buffer: shift-register keypad entry buffer with backspace, clear and
// commit-to-snapshot hand-off. Rev 1.0
module key_entry_buffer #(
  parameter int DIGITS  = 4,
  parameter int KEY_W   = 4,
  parameter int MAX_KEY = 9
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      shift,
  input  logic [KEY_W-1:0]          key,
  input  logic                      backspace,
  input  logic                      clear,
  input  logic                      commit,
  output logic [DIGITS*KEY_W-1:0]   key_buffer,
  output logic [$clog2(DIGITS+1)-1:0] count,
  output logic                      full,
  output logic                      empty,
  output logic [DIGITS*KEY_W-1:0]   load_data,
  output logic                      load_valid,
  output logic                      reject
);

  localparam int          CW      = $clog2(DIGITS + 1);
  localparam int          BW      = DIGITS * KEY_W;
  localparam logic [CW-1:0] C_FULL = CW'(DIGITS);
  localparam logic [31:0] C_MAX   = 32'(MAX_KEY);

  logic [BW-1:0] r_buf;
  logic [CW-1:0] r_cnt;
  logic          r_full;
  logic          r_empty;
  logic [BW-1:0] r_ld_data;
  logic          r_ld_valid;
  logic          r_rej;

  logic [BW-1:0] w_buf_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_commit_ok;
  logic          w_rej;
  logic          w_key_ok;

  assign w_key_ok = ({{(32-KEY_W){1'b0}}, key} <= C_MAX);

  // Strobe priority: clear > commit > shift > backspace; losers are silently dropped.
  always_comb begin
    w_buf_nxt   = r_buf;
    w_cnt_nxt   = r_cnt;
    w_commit_ok = 1'b0;
    w_rej       = 1'b0;
    if (clear) begin
      w_buf_nxt = '0;
      w_cnt_nxt = '0;
    end else if (commit) begin
      if (r_full) begin
        w_commit_ok = 1'b1;
        w_buf_nxt   = '0;
        w_cnt_nxt   = '0;
      end else begin
        w_rej = 1'b1;
      end
    end else if (shift) begin
      if (w_key_ok) begin
        w_buf_nxt = {r_buf[BW-KEY_W-1:0], key};
        if (!r_full) w_cnt_nxt = r_cnt + CW'(1);
      end else begin
        w_rej = 1'b1;
      end
    end else if (backspace) begin
      if (!r_empty) begin
        w_buf_nxt = {{KEY_W{1'b0}}, r_buf[BW-1:KEY_W]};
        w_cnt_nxt = r_cnt - CW'(1);
      end else begin
        w_rej = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_buf      <= '0;
      r_cnt      <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_ld_data  <= '0;
      r_ld_valid <= 1'b0;
      r_rej      <= 1'b0;
    end else begin
      r_buf      <= w_buf_nxt;
      r_cnt      <= w_cnt_nxt;
      r_full     <= (w_cnt_nxt == C_FULL);
      r_empty    <= (w_cnt_nxt == '0);
      r_ld_valid <= w_commit_ok;
      r_rej      <= w_rej;
      if (w_commit_ok) r_ld_data <= r_buf;
    end
  end

  assign key_buffer = r_buf;
  assign count      = r_cnt;
  assign full       = r_full;
  assign empty      = r_empty;
  assign load_data  = r_ld_data;
  assign load_valid = r_ld_valid;
  assign reject     = r_rej;

endmodule
`default_nettype wire

// File: tb/tb_key_entry_buffer.sv
`default_nettype none
// tb_key_entry_buffer: directed scoreboard bench for key_entry_buffer (4 digits x 4 bits, max key 9).
module tb_key_entry_buffer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        shift = 1'b0;
  logic [3:0]  key = '0;
  logic        backspace = 1'b0;
  logic        clear = 1'b0;
  logic        commit = 1'b0;
  logic [15:0] key_buffer;
  logic [2:0]  count;
  logic        full;
  logic        empty;
  logic [15:0] load_data;
  logic        load_valid;
  logic        reject;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       nm;
    logic [15:0] kb;
    logic [2:0]  cnt;
    logic        lv;
    logic [15:0] ld;
    logic        rej;
  } exp_t;

  exp_t exp_q[$];

  key_entry_buffer #(.DIGITS(4), .KEY_W(4), .MAX_KEY(9)) dut (
    .clock      (clock),
    .reset      (reset),
    .shift      (shift),
    .key        (key),
    .backspace  (backspace),
    .clear      (clear),
    .commit     (commit),
    .key_buffer (key_buffer),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .load_data  (load_data),
    .load_valid (load_valid),
    .reject     (reject)
  );

  always #5 clock = ~clock;

  task automatic check(input exp_t e);
    logic efull, eempty;
    efull  = (e.cnt == 3'd4);
    eempty = (e.cnt == 3'd0);
    n_tests++;
    if (key_buffer !== e.kb || count !== e.cnt || full !== efull || empty !== eempty ||
        load_valid !== e.lv || load_data !== e.ld || reject !== e.rej) begin
      n_fail++;
      $display("FAIL %s: got kb=%h cnt=%0d full=%b empty=%b lv=%b ld=%h rej=%b; want kb=%h cnt=%0d full=%b empty=%b lv=%b ld=%h rej=%b",
               e.nm, key_buffer, count, full, empty, load_valid, load_data, reject,
               e.kb, e.cnt, efull, eempty, e.lv, e.ld, e.rej);
    end
  endtask

  // Monitor: one expectation per clock edge issued by the stimulus.
  always @(posedge clock) begin
    #1;
    if (exp_q.size() > 0) check(exp_q.pop_front());
  end

  // Called at a negedge; drives strobes for the next edge and returns at the following negedge.
  task automatic step(input string nm, input logic s, input logic [3:0] k, input logic b,
                      input logic c, input logic m, input logic [15:0] ekb,
                      input logic [2:0] ecnt, input logic elv, input logic [15:0] eld,
                      input logic erej);
    exp_t e;
    shift = s; key = k; backspace = b; clear = c; commit = m;
    e.nm = nm; e.kb = ekb; e.cnt = ecnt; e.lv = elv; e.ld = eld; e.rej = erej;
    exp_q.push_back(e);
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    shift = 1'b0; key = '0; backspace = 1'b0; clear = 1'b0; commit = 1'b0;
  endtask

  initial begin
    exp_t e;
    #1 reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    e.nm = "reset_state"; e.kb = 16'h0; e.cnt = 0; e.lv = 0; e.ld = 16'h0; e.rej = 0;
    check(e);

    //    name          sh key bs cl cm  kb       cnt lv ld       rej
    step("sh1",         1, 1,  0, 0, 0, 16'h0001, 1, 0, 16'h0000, 0);
    step("sh2",         1, 2,  0, 0, 0, 16'h0012, 2, 0, 16'h0000, 0);
    step("sh3",         1, 3,  0, 0, 0, 16'h0123, 3, 0, 16'h0000, 0);
    step("sh4_full",    1, 4,  0, 0, 0, 16'h1234, 4, 0, 16'h0000, 0);
    step("sh5_overflw", 1, 5,  0, 0, 0, 16'h2345, 4, 0, 16'h0000, 0);
    step("clear",       0, 0,  0, 1, 0, 16'h0000, 0, 0, 16'h0000, 0);
    step("sh1b",        1, 1,  0, 0, 0, 16'h0001, 1, 0, 16'h0000, 0);
    step("sh2b",        1, 2,  0, 0, 0, 16'h0012, 2, 0, 16'h0000, 0);
    step("bs1",         0, 0,  1, 0, 0, 16'h0001, 1, 0, 16'h0000, 0);
    step("bs2",         0, 0,  1, 0, 0, 16'h0000, 0, 0, 16'h0000, 0);
    step("bs_empty",    0, 0,  1, 0, 0, 16'h0000, 0, 0, 16'h0000, 1);
    step("rej_drop",    0, 0,  0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0);
    step("sh1c",        1, 1,  0, 0, 0, 16'h0001, 1, 0, 16'h0000, 0);
    step("sh2c",        1, 2,  0, 0, 0, 16'h0012, 2, 0, 16'h0000, 0);
    step("sh3c",        1, 3,  0, 0, 0, 16'h0123, 3, 0, 16'h0000, 0);
    step("sh_badkey",   1, 10, 0, 0, 0, 16'h0123, 3, 0, 16'h0000, 1);
    step("cm_notfull",  0, 0,  0, 0, 1, 16'h0123, 3, 0, 16'h0000, 1);
    step("sh4c",        1, 4,  0, 0, 0, 16'h1234, 4, 0, 16'h0000, 0);
    step("commit",      0, 0,  0, 0, 1, 16'h0000, 0, 1, 16'h1234, 0);
    step("lv_drop",     0, 0,  0, 0, 0, 16'h0000, 0, 0, 16'h1234, 0);
    step("sh5d",        1, 5,  0, 0, 0, 16'h0005, 1, 0, 16'h1234, 0);
    step("sh6d",        1, 6,  0, 0, 0, 16'h0056, 2, 0, 16'h1234, 0);
    step("sh7d",        1, 7,  0, 0, 0, 16'h0567, 3, 0, 16'h1234, 0);
    step("sh8d",        1, 8,  0, 0, 0, 16'h5678, 4, 0, 16'h1234, 0);
    step("clr_over_cm", 0, 0,  0, 1, 1, 16'h0000, 0, 0, 16'h1234, 0);
    step("sh9e",        1, 9,  0, 0, 0, 16'h0009, 1, 0, 16'h1234, 0);
    step("sh8e",        1, 8,  0, 0, 0, 16'h0098, 2, 0, 16'h1234, 0);
    step("sh7e",        1, 7,  0, 0, 0, 16'h0987, 3, 0, 16'h1234, 0);
    step("sh6e",        1, 6,  0, 0, 0, 16'h9876, 4, 0, 16'h1234, 0);
    step("cm_over_sh",  1, 1,  0, 0, 1, 16'h0000, 0, 1, 16'h9876, 0);
    step("sh_over_bs",  1, 7,  1, 0, 0, 16'h0007, 1, 0, 16'h9876, 0);
    step("cm_rej_hold", 0, 0,  0, 0, 1, 16'h0007, 1, 0, 16'h9876, 1);
    step("sh5f",        1, 5,  0, 0, 0, 16'h0075, 2, 0, 16'h9876, 0);

    // Asynchronous reset in the middle of a cycle, with a partial entry present.
    idle_inputs();
    @(posedge clock);
    #3 reset = 1'b1;
    #1;
    e.nm = "async_reset"; e.kb = 16'h0; e.cnt = 0; e.lv = 0; e.ld = 16'h0; e.rej = 0;
    check(e);
    @(negedge clock);
    reset = 1'b0;
    step("first_edge",  1, 3,  0, 0, 0, 16'h0003, 1, 0, 16'h0000, 0);
    idle_inputs();

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clock);
    #2;
    if (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
